// File: rtl/seq_chunk_subtractor_if.sv
// Handshake and operand/result bundle for seq_chunk_subtractor.
// The master drives the request and operands; the slave returns status and result.
interface seq_chunk_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             overflow;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, overflow
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, overflow
    );
endinterface

// File: rtl/seq_chunk_subtractor.sv
// Multi-cycle signed subtractor: computes a - b - bin one CHUNK-bit slice per cycle,
// LSB slice first, rippling the borrow through a register between slices.
module seq_chunk_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                  clk,
    input logic                  rst_n,
    seq_chunk_subtractor_if.slave bus
);
    localparam int unsigned NUM = WIDTH / CHUNK;
    localparam int unsigned CW  = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_borrow;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_busy;
    logic             r_done;

    int unsigned      w_base;
    logic [CHUNK:0]   w_slice;
    logic             w_borrow;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;

    // Extra top bit of w_slice goes to 1 exactly when the slice needs a borrow.
    always_comb begin
        w_base   = 32'(r_cnt) * CHUNK;
        w_slice  = {1'b0, r_a[w_base +: CHUNK]} - {1'b0, r_b[w_base +: CHUNK]}
                   - {{CHUNK{1'b0}}, r_borrow};
        w_borrow = w_slice[CHUNK];
        w_res    = r_res;
        w_res[w_base +: CHUNK] = w_slice[CHUNK-1:0];
        w_ovf    = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_res[WIDTH-1] != r_a[WIDTH-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle, StDone: begin
                    if (bus.start) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= StRun;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_res    <= w_res;
                    r_borrow <= w_borrow;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state <= StDone;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_diff  <= w_res;
                        r_bout  <= w_borrow;
                        r_ovf   <= w_ovf;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.diff     = r_diff;
    assign bus.bout     = r_bout;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_seq_chunk_subtractor.sv
// Directed bench for seq_chunk_subtractor with default WIDTH=32, CHUNK=8.
module tb_seq_chunk_subtractor;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned LAT   = WIDTH / CHUNK;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    seq_chunk_subtractor_if #(.WIDTH(WIDTH)) bus ();

    seq_chunk_subtractor #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] d, input logic bo,
                              input logic ov);
        check_eq({tag, ".diff"}, 64'(bus.diff), 64'(d));
        check_eq({tag, ".bout"}, 64'(bus.bout), 64'(bo));
        check_eq({tag, ".ovf"},  64'(bus.overflow), 64'(ov));
    endtask

    // Issue one operation, check busy/done timing every cycle and the final result.
    task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic bin, input logic [WIDTH-1:0] d, input logic bo,
                          input logic ov);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= int'(LAT); i++) begin
            check_eq({tag, ".busy"}, 64'(bus.busy), (i == 1) ? 64'd1 : 64'd1);
            tick();
        end
        check_eq({tag, ".done"}, 64'(bus.done), 64'd1);
        check_eq({tag, ".busy_done"}, 64'(bus.busy), 64'd0);
        check_outs(tag, d, bo, ov);
        tick();
        check_eq({tag, ".done_clr"}, 64'(bus.done), 64'd0);
        check_outs({tag, ".hold"}, d, bo, ov);
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        #12;
        check_eq("rst.busy", 64'(bus.busy), 64'd0);
        check_eq("rst.done", 64'(bus.done), 64'd0);
        check_outs("rst", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("ovf_lo",  32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
        run_op("ovf_hi",  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b1);
        run_op("ripple",  32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("neg50",   32'd100,       32'd150,       1'b0, 32'hFFFF_FFCE, 1'b1, 1'b0);
        run_op("plain",   32'h1234_5678, 32'h0123_4567, 1'b0, 32'h1111_1111, 1'b0, 1'b0);
        run_op("bin1",    32'd5,         32'd2,         1'b1, 32'd2,         1'b0, 1'b0);

        // Start pulse while running must not disturb the captured operands.
        bus.start = 1'b1;
        bus.a     = 32'd200;
        bus.b     = 32'd50;
        bus.bin   = 1'b0;
        tick();
        bus.start = 1'b0;
        check_eq("srun.busy1", 64'(bus.busy), 64'd1);
        tick();
        bus.start = 1'b1;
        bus.a     = 32'd7;
        bus.b     = 32'd7;
        check_eq("srun.busy2", 64'(bus.busy), 64'd1);
        tick();
        bus.start = 1'b0;
        check_eq("srun.busy3", 64'(bus.busy), 64'd1);
        check_eq("srun.nodone3", 64'(bus.done), 64'd0);
        tick();
        check_eq("srun.busy4", 64'(bus.busy), 64'd1);
        tick();
        check_eq("srun.done", 64'(bus.done), 64'd1);
        check_outs("srun", 32'd150, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("srun.single_done", 64'(bus.done), 64'd0);
            check_eq("srun.idle_busy", 64'(bus.busy), 64'd0);
        end

        // Back-to-back: start held in the DONE cycle.
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < int'(LAT); i++) tick();
        check_eq("b2b.done1", 64'(bus.done), 64'd1);
        check_outs("b2b.first", 32'd7, 1'b0, 1'b0);
        bus.start = 1'b1;
        bus.a     = 32'hFFFF_FF9C;
        bus.b     = 32'hFFFF_FF38;
        tick();
        bus.start = 1'b0;
        check_eq("b2b.busy", 64'(bus.busy), 64'd1);
        check_eq("b2b.done_clr", 64'(bus.done), 64'd0);
        check_outs("b2b.held", 32'd7, 1'b0, 1'b0);
        for (int i = 0; i < int'(LAT) - 1; i++) tick();
        check_eq("b2b.early", 64'(bus.done), 64'd0);
        tick();
        check_eq("b2b.done2", 64'(bus.done), 64'd1);
        check_outs("b2b.second", 32'd100, 1'b0, 1'b0);
        tick();

        // Reset during the second RUN cycle.
        bus.start = 1'b1;
        bus.a     = 32'h0000_1234;
        bus.b     = 32'd1;
        tick();
        bus.start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mrst.busy", 64'(bus.busy), 64'd0);
        check_eq("mrst.done", 64'(bus.done), 64'd0);
        check_outs("mrst", 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < int'(LAT) + 2; i++) begin
            tick();
            check_eq("mrst.no_done", 64'(bus.done), 64'd0);
            check_eq("mrst.no_busy", 64'(bus.busy), 64'd0);
        end
        run_op("post_rst", 32'd5, 32'd5, 1'b0, 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_chunk_subtractor.md
SEQ_CHUNK_SUBTRACTOR -- requirements
Module: seq_chunk_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving operand and result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, giving bits processed per cycle; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK SHALL be at least 1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, request to begin a subtraction.
REQ-006 SHALL have port a, input, WIDTH, the signed minuend.
REQ-007 SHALL have port b, input, WIDTH, the signed subtrahend.
REQ-008 SHALL have port bin, input, 1, the borrow-in.
REQ-009 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-010 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-011 SHALL have port diff, output, WIDTH, the signed result a - b - bin.
REQ-012 SHALL have port bout, output, 1, the borrow-out: 1 when unsigned a < unsigned b + bin.
REQ-013 SHALL have port overflow, output, 1, the signed overflow flag.

Function
REQ-014 SHALL implement an FSM with the states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start=1 at a rising edge SHALL capture a, b and bin, clear the chunk counter, load the borrow register with bin, and enter RUN.
REQ-016 start while in RUN SHALL be ignored, and the operands captured for the current operation SHALL NOT change.
REQ-017 Each RUN cycle SHALL compute one CHUNK slice, chunk index 0 (LSBs) first, as a_slice - b_slice - borrow, store it in an internal result register, and propagate the borrow to the next slice.
REQ-018 After the final chunk (index WIDTH/CHUNK-1), the FSM SHALL enter DONE.
REQ-019 Latency SHALL be fixed: with start sampled at edge k, done SHALL be high for exactly the cycle following edge k+WIDTH/CHUNK, which is 4 cycles for the default parameters.
REQ-020 busy SHALL be high from edge k through edge k+WIDTH/CHUNK, and low in IDLE and DONE.
REQ-021 diff, bout and overflow SHALL update only on the edge that enters DONE, and SHALL hold until the next completion or reset.
REQ-022 overflow SHALL equal (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the captured operands.
REQ-023 bout SHALL be the borrow out of the final chunk.
REQ-024 The result SHALL be bit-exact with WIDTH-bit two's-complement a - b - bin, with wrap-around and no saturation.
REQ-025 From DONE with start=0, the FSM SHALL return to IDLE on the next edge.
REQ-026 From DONE with start=1, a new operation SHALL begin immediately, giving back-to-back throughput of one result per WIDTH/CHUNK+1 cycles.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE and clear busy, done, diff, bout, overflow, the counter, the borrow register and the captured operands to 0.
REQ-028 Reset asserted mid-RUN SHALL abort the operation, and no done pulse SHALL follow after reset release.
REQ-029 After release, the block SHALL accept start on the first rising edge at which rst_n=1.

Verification
REQ-030 Signed overflow low end: a=-2147483648, b=1, bin=0 -> diff=2147483647, overflow=1, bout=0, with done exactly 4 cycles after start.
REQ-031 Signed overflow high end: a=2147483647, b=-1, bin=0 -> diff=-2147483648, overflow=1, bout=1.
REQ-032 Full-width borrow ripple: a=0, b=0, bin=1 -> diff=-1 (all ones), bout=1, overflow=0; separately, a=100, b=150, bin=0 -> diff=-50, bout=1, overflow=0.
REQ-033 Start during RUN: start a=200, b=50; pulse start with a=7, b=7 two cycles later -> single done with diff=150, and busy is never dropped early.
REQ-034 Back-to-back operation: hold start=1 in the DONE cycle with a=-100, b=-200 -> the first result is held, and the next done arrives 4 cycles later with diff=100, bout=0, overflow=0.
REQ-035 Reset mid-operation: assert rst_n=0 during the 2nd RUN cycle -> all outputs 0 immediately, no done pulse after release, and a subsequent start a=5, b=5 gives diff=0, bout=0.
